// File: rtl/seq_divider.sv
// Iterative signed integer divider for the execute stage.
// Restoring algorithm, one quotient bit per clock, truncation toward zero.
// Divide-by-zero is flagged on data_exception instead of producing a quotient.
// The port named 'reset' is asynchronous and active-low.

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Control strobes produced by the FSM and consumed by the datapath.
    logic load;
    logic iterate;
    logic publish;

    // Datapath registers.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             exc_flag;

    // Operand magnitudes and per-iteration arithmetic.
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             b_zero;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] signed_quo;

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps
    // exactly onto 2**(WIDTH-1). A remainder is always below the divisor
    // magnitude (at most 2**(WIDTH-1)), so its top bit is zero before the
    // shift and dropping it loses nothing.
    always_comb begin
        mag_a      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        b_zero     = (data_operandB == '0);
        rem_shift  = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        diff       = {1'b0, rem_shift} - {1'b0, dvs};
        borrow     = diff[WIDTH];
        signed_quo = sign_q ? -quo : quo;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes; a start request always wins and
    // restarts from the operand latch, even mid-iteration or in FIX.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        iterate    = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                next_state = IDLE;
            end
            RUN: begin
                iterate = 1'b1;
                if (count == LAST_COUNT) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                publish    = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (ctrl_div) begin
            load       = 1'b1;
            iterate    = 1'b0;
            next_state = b_zero ? FIX : RUN;
        end
    end

    // Iteration datapath: latch operands on start, then shift/subtract once per cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            exc_flag <= 1'b0;
        end else if (load) begin
            dvd      <= mag_a;
            dvs      <= mag_b;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            exc_flag <= b_zero;
        end else if (iterate) begin
            dvd   <= {dvd[WIDTH-2:0], 1'b0};
            rem   <= borrow ? rem_shift : diff[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], ~borrow};
            count <= count + CW'(1);
        end
    end

    // Result registers: updated only when an op completes, otherwise held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= publish;
            if (publish) begin
                data_result    <= signed_quo;
                data_exception <= exc_flag;
            end
        end
    end

    // Stall request follows the FSM: any state other than IDLE is in flight.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule
